// File: rtl/aes_round_ctrl.sv
// AES round-sequencing controller: steps an external round counter and decodes
// per-cycle round strobes plus the start/result valid-ready handshakes.
module aes_round_ctrl #(
  parameter int NR       = 10,
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start_valid,
  output logic                o_start_ready,
  output logic                o_cnt_en,
  input  logic [CNT_SIZE-1:0] i_round,
  input  logic                i_cnt_flag,
  output logic [CNT_SIZE-1:0] o_key_idx,
  output logic                o_load,
  output logic                o_round_en,
  output logic                o_final_round,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_busy,
  output logic                o_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CNT_SIZE-1:0] LAST_MID_ROUND = CNT_SIZE'(NR - 1);
  localparam logic [CNT_SIZE-1:0] LAST_ROUND     = CNT_SIZE'(NR);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       start_hs;
  logic       err_nxt;

  // A new block is only taken when the counter sits at zero, or straight out
  // of DONE when the sink is draining the previous result in the same cycle.
  always_comb begin
    o_start_ready = 1'b0;
    case (state)
      IDLE:    o_start_ready = (i_round == '0);
      DONE:    o_start_ready = i_out_ready;
      default: o_start_ready = 1'b0;
    endcase
  end

  assign start_hs = i_start_valid & o_start_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_hs) state_nxt = INIT;
      INIT:  state_nxt = ROUND;
      ROUND: if (i_round == LAST_MID_ROUND) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE: begin
        if (i_out_ready) state_nxt = i_start_valid ? INIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final round must coincide with the counter reporting NR; anything else
  // means the counter and controller have drifted, which is latched until reset.
  assign err_nxt = o_err |
                   ((state == FINAL) & (~i_cnt_flag | (i_round != LAST_ROUND)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o_err <= 1'b0;
    end else begin
      state <= state_nxt;
      o_err <= err_nxt;
    end
  end

  assign o_key_idx     = i_round;
  assign o_load        = (state == INIT);
  assign o_round_en    = (state == ROUND);
  assign o_final_round = (state == FINAL);
  assign o_out_valid   = (state == DONE);
  assign o_cnt_en      = (state == INIT) | (state == ROUND) | (state == FINAL);
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural round counter that can
// be overridden to inject a stuck count or a missing terminal flag.
module tb_aes_round_ctrl;

  localparam int NR       = 10;
  localparam int CNT_SIZE = 4;

  logic                clk;
  logic                rst_n;
  logic                i_start_valid;
  logic                o_start_ready;
  logic                o_cnt_en;
  logic [CNT_SIZE-1:0] i_round;
  logic                i_cnt_flag;
  logic [CNT_SIZE-1:0] o_key_idx;
  logic                o_load;
  logic                o_round_en;
  logic                o_final_round;
  logic                o_out_valid;
  logic                i_out_ready;
  logic                o_busy;
  logic                o_err;

  logic [CNT_SIZE-1:0] cnt;
  logic                stub_hold;
  logic [CNT_SIZE-1:0] stub_value;
  logic                flag_kill;

  int checkCount;
  int failCount;

  aes_round_ctrl #(.NR(NR), .CNT_SIZE(CNT_SIZE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start_valid (i_start_valid),
    .o_start_ready (o_start_ready),
    .o_cnt_en      (o_cnt_en),
    .i_round       (i_round),
    .i_cnt_flag    (i_cnt_flag),
    .o_key_idx     (o_key_idx),
    .o_load        (o_load),
    .o_round_en    (o_round_en),
    .o_final_round (o_final_round),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference counter: +1 per enabled cycle, wraps NR -> 0, flag at NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (o_cnt_en) cnt <= (cnt == CNT_SIZE'(NR)) ? '0 : cnt + 1'b1;
  end

  assign i_round    = stub_hold ? stub_value : cnt;
  assign i_cnt_flag = (cnt == CNT_SIZE'(NR)) & ~flag_kill;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start_valid, input logic out_ready);
    i_start_valid = start_valid;
    i_out_ready   = out_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one block from IDLE and returns cycles from accept to valid.
  task automatic startAndWait(output int lat);
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    lat = 1;
    while (!o_out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic drainResult();
    applyStimulus(1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    int lat;
    int cyc;
    int validSeen;
    int firstValid;
    int secondValid;
    int loadAfterValid;

    checkCount = 0;
    failCount  = 0;
    stub_hold  = 1'b0;
    stub_value = '0;
    flag_kill  = 1'b0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #12 rst_n = 1'b1;
    step();

    $display("[TB] reset state");
    checkOutput("rst_start_ready", o_start_ready, 1);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_cnt_en", o_cnt_en, 0);
    checkOutput("rst_out_valid", o_out_valid, 0);
    checkOutput("rst_err", o_err, 0);

    $display("[TB] single block sequence");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("init_load", o_load, 1);
    checkOutput("init_key_idx", o_key_idx, 0);
    checkOutput("init_start_ready", o_start_ready, 0);
    for (int k = 1; k <= NR - 1; k++) begin
      step();
      checkOutput($sformatf("round_en_%0d", k), o_round_en, 1);
      checkOutput($sformatf("round_key_%0d", k), o_key_idx, k);
    end
    step();
    checkOutput("final_round", o_final_round, 1);
    checkOutput("final_key_idx", o_key_idx, NR);
    checkOutput("final_round_en", o_round_en, 0);
    step();
    checkOutput("done_valid", o_out_valid, 1);
    checkOutput("done_key_idx", o_key_idx, 0);

    $display("[TB] sink stall in DONE");
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("stall_valid", o_out_valid, 1);
      checkOutput("stall_cnt_en", o_cnt_en, 0);
      checkOutput("stall_start_ready", o_start_ready, 0);
    end
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("done_start_ready", o_start_ready, 1);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_busy", o_busy, 0);
    checkOutput("release_valid", o_out_valid, 0);

    $display("[TB] back-to-back blocks");
    applyStimulus(1'b1, 1'b1);
    validSeen = 0;
    firstValid = 0;
    secondValid = 0;
    loadAfterValid = 0;
    cyc = 0;
    while (validSeen < 2 && cyc < 60) begin
      step();
      cyc++;
      if (validSeen == 1 && cyc == firstValid + 1) loadAfterValid = o_load;
      if (o_out_valid) begin
        validSeen++;
        if (validSeen == 1) firstValid = cyc;
        else secondValid = cyc;
      end
    end
    checkOutput("b2b_valid_count", validSeen, 2);
    checkOutput("b2b_gap", secondValid - firstValid, NR + 2);
    checkOutput("b2b_direct_init", loadAfterValid, 1);
    applyStimulus(1'b0, 1'b1);
    cyc = 0;
    while (o_busy && cyc < 30) begin
      step();
      cyc++;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_idle", o_busy, 0);

    $display("[TB] counter desync error");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    cyc = 0;
    while (!o_final_round && cyc < 30) begin
      step();
      cyc++;
    end
    checkOutput("err_reach_final", o_final_round, 1);
    flag_kill = 1'b1;
    #1;
    checkOutput("err_before", o_err, 0);
    step();
    flag_kill = 1'b0;
    checkOutput("err_set", o_err, 1);
    checkOutput("err_done_valid", o_out_valid, 1);
    drainResult();
    startAndWait(lat);
    checkOutput("err_next_latency", lat, NR + 2);
    checkOutput("err_sticky", o_err, 1);
    drainResult();
    rst_n = 1'b0;
    #1;
    checkOutput("err_cleared", o_err, 0);
    #10 rst_n = 1'b1;
    step();

    $display("[TB] reset mid-block");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    cyc = 0;
    while (!(o_round_en && o_key_idx == 5) && cyc < 30) begin
      step();
      cyc++;
    end
    checkOutput("mid_key_idx", o_key_idx, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", o_busy, 0);
    checkOutput("mid_round_en", o_round_en, 0);
    checkOutput("mid_cnt_en", o_cnt_en, 0);
    checkOutput("mid_key_reset", o_key_idx, 0);
    checkOutput("mid_valid", o_out_valid, 0);
    #20 rst_n = 1'b1;
    step();
    checkOutput("mid_after_valid", o_out_valid, 0);
    startAndWait(lat);
    checkOutput("mid_restart_latency", lat, NR + 2);
    drainResult();

    $display("[TB] start refused with nonzero count");
    stub_hold  = 1'b1;
    stub_value = 4'd3;
    #1;
    checkOutput("hold_start_ready", o_start_ready, 0);
    applyStimulus(1'b1, 1'b0);
    step();
    checkOutput("hold_busy", o_busy, 0);
    checkOutput("hold_load", o_load, 0);
    applyStimulus(1'b0, 1'b0);
    stub_hold = 1'b0;
    #1;
    checkOutput("hold_release_ready", o_start_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
